// File: rtl/delay_line_pkg.sv
// Shared types and constants for the delay-line measurement front end.
package delay_line_pkg;

    // Default width of the measurement cycle counter and of the result bus.
    localparam int unsigned DEFAULT_CNT_WIDTH = 16;

    // Interval measurement sequencer states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        COUNTING = 2'd2,
        DONE     = 2'd3
    } meas_state_t;

endpackage

// File: rtl/cycle_timer.sv
// Clearable incrementing counter with a terminal-count compare output.
module cycle_timer
    import delay_line_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_CNT_WIDTH,
    parameter int unsigned TERMINAL = 999
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count,
    output logic             o_terminal
);

    logic [WIDTH-1:0] r_count;

    // Counter register: clear has priority over increment, otherwise hold.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count    = r_count;
    assign o_terminal = (r_count == WIDTH'(TERMINAL));

endmodule

// File: rtl/interval_measure_ctrl.sv
// Start/stop interval measurement sequencer with timeout, abort and a
// valid/ready result port. All outputs come straight from flops.
module interval_measure_ctrl
    import delay_line_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 start_edge,
    input  logic                 stop_edge,
    output logic                 busy,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [CNT_WIDTH-1:0] result,
    output logic                 timed_out
);

    meas_state_t          r_state;
    meas_state_t          w_next_state;

    logic                 w_timer_clear;
    logic                 w_timer_inc;
    logic                 w_timer_tc;
    logic [CNT_WIDTH-1:0] w_timer;

    logic                 w_load_result;
    logic [CNT_WIDTH-1:0] w_result_d;
    logic                 w_timed_out_d;

    logic                 r_busy;
    logic                 r_valid;
    logic [CNT_WIDTH-1:0] r_result;
    logic                 r_timed_out;

    // Shared timer for both the ARMED wait and the COUNTING interval.
    cycle_timer #(
        .WIDTH    (CNT_WIDTH),
        .TERMINAL (TIMEOUT - 1)
    ) u_cycle_timer (
        .clk        (clk),
        .n_reset    (n_reset),
        .i_clear    (w_timer_clear),
        .i_inc      (w_timer_inc),
        .o_count    (w_timer),
        .o_terminal (w_timer_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: abort beats edges, edges beat the timeout.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (arm) w_next_state = ARMED;
            end
            ARMED: begin
                if (abort)           w_next_state = IDLE;
                else if (start_edge) w_next_state = COUNTING;
                else if (w_timer_tc) w_next_state = DONE;
            end
            COUNTING: begin
                if (abort)                        w_next_state = IDLE;
                else if (stop_edge || w_timer_tc) w_next_state = DONE;
            end
            DONE: begin
                if (result_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Output/datapath decode: timer control and the result to capture on completion.
    always_comb begin
        w_timer_clear = 1'b0;
        w_timer_inc   = 1'b0;
        w_load_result = 1'b0;
        w_result_d    = '0;
        w_timed_out_d = 1'b0;
        case (r_state)
            IDLE: begin
                w_timer_clear = 1'b1;
            end
            ARMED: begin
                if (start_edge) w_timer_clear = 1'b1;
                else            w_timer_inc   = 1'b1;
                // Timeout before any start edge reports a zero count.
                if (!abort && !start_edge && w_timer_tc) begin
                    w_load_result = 1'b1;
                    w_result_d    = '0;
                    w_timed_out_d = 1'b1;
                end
            end
            COUNTING: begin
                w_timer_inc = 1'b1;
                if (!abort && stop_edge) begin
                    // Timer holds cycles since start minus one, so adjacent pulses give 1.
                    w_load_result = 1'b1;
                    w_result_d    = w_timer + CNT_WIDTH'(1);
                    w_timed_out_d = 1'b0;
                end else if (!abort && w_timer_tc) begin
                    w_load_result = 1'b1;
                    w_result_d    = CNT_WIDTH'(TIMEOUT);
                    w_timed_out_d = 1'b1;
                end
            end
            DONE: begin
                w_timer_clear = 1'b1;
            end
            default: begin
                w_timer_clear = 1'b1;
            end
        endcase
    end

    // Output registers: status follows the next state, result fields load once and hold through DONE.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_result    <= '0;
            r_timed_out <= 1'b0;
        end else begin
            r_busy  <= (w_next_state != IDLE);
            r_valid <= (w_next_state == DONE);
            if (w_load_result) begin
                r_result    <= w_result_d;
                r_timed_out <= w_timed_out_d;
            end
        end
    end

    assign busy         = r_busy;
    assign result_valid = r_valid;
    assign result       = r_result;
    assign timed_out    = r_timed_out;

endmodule

// File: tb/tb_interval_measure_ctrl.sv
// Randomized scoreboard bench for interval_measure_ctrl. The driver computes
// each measurement's outcome from edge timing with plain arithmetic and queues
// it; an independent monitor compares whenever the DUT presents a result.
module tb_interval_measure_ctrl;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [CNT_W-1:0] res;
        logic             to;
        int               cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             n_reset;
    logic             arm;
    logic             abort;
    logic             start_edge;
    logic             stop_edge;
    logic             busy;
    logic             result_valid;
    logic             result_ready;
    logic [CNT_W-1:0] result;
    logic             timed_out;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b1;
    exp_t exp_q[$];

    interval_measure_ctrl #(
        .CNT_WIDTH (CNT_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .arm          (arm),
        .abort        (abort),
        .start_edge   (start_edge),
        .stop_edge    (stop_edge),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .timed_out    (timed_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Inputs change 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        arm        = 1'b0;
        abort      = 1'b0;
        start_edge = 1'b0;
        stop_edge  = 1'b0;
    endtask

    // One measurement. Edge indices are counted in clock edges after the edge
    // that samples arm (index 0); 0 means "not driven". hold = cycles of
    // forced backpressure once the result is presented.
    task automatic run_meas(input int start_at, input int stop_a, input int stop_b,
                            input int abort_at, input bit arm_noise, input int hold);
        int   t_end;
        int   first_stop;
        bit   has_res;
        exp_t e;
        int   waited;

        // Reference outcome from the measurement rules.
        if (start_at == 0 || start_at > TIMEOUT) begin
            t_end = TIMEOUT;
            e.res = '0;
            e.to  = 1'b1;
        end else begin
            first_stop = start_at + TIMEOUT + 1;
            if (stop_a > start_at && stop_a < first_stop) first_stop = stop_a;
            if (stop_b > start_at && stop_b < first_stop) first_stop = stop_b;
            if (first_stop - start_at <= TIMEOUT) begin
                t_end = first_stop;
                e.res = CNT_W'(first_stop - start_at);
                e.to  = 1'b0;
            end else begin
                t_end = start_at + TIMEOUT;
                e.res = CNT_W'(TIMEOUT);
                e.to  = 1'b1;
            end
        end
        has_res = !(abort_at != 0 && abort_at <= t_end);
        if (!has_res) t_end = abort_at;

        check("idle_before_arm", busy, 0);
        for (int k = 0; k <= t_end; k++) begin
            arm          = (k == 0) || (arm_noise && $urandom_range(3) == 0);
            start_edge   = (start_at != 0) && (k == start_at);
            stop_edge    = (stop_a != 0 && k == stop_a) || (stop_b != 0 && k == stop_b);
            abort        = (abort_at != 0) && (k == abort_at);
            result_ready = ($urandom_range(1) == 1);
            tick();
            if (k == 0) begin
                check("busy_after_arm", busy, 1);
                if (has_res) begin
                    e.cyc = cyc + t_end;
                    exp_q.push_back(e);
                end
            end
        end
        clear_inputs();
        if (!has_res) check("busy_after_abort", busy, 0);

        // Drain: noise on every input while DONE, including arm in the handshake cycle.
        waited = 0;
        while (busy && waited < 300) begin
            result_ready = (waited < hold) ? 1'b0 : ($urandom_range(1) == 1);
            arm          = result_valid && ($urandom_range(2) == 0);
            abort        = result_valid && ($urandom_range(3) == 0);
            start_edge   = ($urandom_range(3) == 0);
            stop_edge    = ($urandom_range(3) == 0);
            tick();
            waited++;
        end
        clear_inputs();
        check("measurement_completes", busy, 0);
    endtask

    // Monitor: compares every presented result against the scoreboard.
    initial begin : monitor
        bit   prev_valid;
        bit   post_hs;
        exp_t f;
        prev_valid = 1'b0;
        post_hs    = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (post_hs) begin
                    check("busy_after_xfer", busy, 0);
                    check("valid_after_xfer", result_valid, 0);
                    post_hs = 1'b0;
                end
                if (result_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", result_valid, 0);
                    end else begin
                        f = exp_q[0];
                        if (!prev_valid) begin
                            check("valid_cycle", cyc, f.cyc);
                            check("result", result, f.res);
                            check("timed_out", timed_out, f.to);
                        end else begin
                            check("result_stable", result, f.res);
                            check("timed_out_stable", timed_out, f.to);
                        end
                        if (result_ready) begin
                            void'(exp_q.pop_front());
                            post_hs = 1'b1;
                        end
                    end
                end
            end
            prev_valid = result_valid;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cyc);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : driver
        n_reset      = 1'b0;
        result_ready = 1'b0;
        clear_inputs();
        #12;
        check("reset_busy", busy, 0);
        check("reset_valid", result_valid, 0);
        check("reset_result", result, 0);
        check("reset_timed_out", timed_out, 0);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        tick();
        tick();

        // Directed cases.
        run_meas(3, 10, 0, 0, 1'b0, 0);   // basic: 7
        run_meas(2, 7, 0, 0, 1'b1, 20);   // backpressure: 5
        run_meas(0, 0, 0, 0, 1'b0, 0);    // ARMED timeout: 0, timed out
        run_meas(2, 0, 0, 0, 1'b0, 0);    // COUNTING timeout: TIMEOUT, timed out
        run_meas(2, 12, 0, 6, 1'b0, 0);   // abort while counting
        run_meas(1, 4, 0, 0, 1'b0, 0);    // fresh arm after abort: 3
        run_meas(4, 4, 6, 0, 1'b0, 0);    // both edges together, stop at +2
        run_meas(1, 17, 0, 0, 1'b0, 0);   // stop on the timeout cycle wins
        run_meas(16, 18, 0, 0, 1'b0, 0);  // start on the timeout cycle wins
        run_meas(2, 5, 0, 5, 1'b0, 0);    // abort beats stop
        run_meas(0, 0, 0, 3, 1'b0, 0);    // abort while armed
        run_meas(3, 3, 1, 0, 1'b1, 2);    // stray stops before start

        // Randomized measurements.
        for (int i = 0; i < 40; i++) begin
            int s;
            int a;
            int b;
            int ab;
            s  = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(1, TIMEOUT + 3));
            a  = s + int'($urandom_range(0, TIMEOUT + 3));
            b  = ($urandom_range(2) == 0) ? int'($urandom_range(1, s + 1)) : 0;
            ab = ($urandom_range(5) == 0) ? int'($urandom_range(1, 20)) : 0;
            run_meas(s, a, b, ab, ($urandom_range(1) == 1), int'($urandom_range(0, 3)));
        end

        run_meas(2, 5, 0, 0, 1'b0, 0);    // leaves result = 3

        // Asynchronous reset mid-COUNTING.
        mon_en       = 1'b0;
        result_ready = 1'b0;
        arm = 1'b1;        tick();
        arm = 1'b0;        start_edge = 1'b1; tick();
        start_edge = 1'b0; tick();
        tick();
        check("busy_counting", busy, 1);
        @(negedge clk);
        #2;
        n_reset = 1'b0;
        #1;
        check("rst_cnt_busy", busy, 0);
        check("rst_cnt_valid", result_valid, 0);
        check("rst_cnt_result", result, 0);
        check("rst_cnt_timed_out", timed_out, 0);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        tick();

        // Asynchronous reset mid-DONE.
        arm = 1'b1;        tick();
        arm = 1'b0;        start_edge = 1'b1; tick();
        start_edge = 1'b0; stop_edge = 1'b1;  tick();
        stop_edge = 1'b0;  tick();
        check("done_valid", result_valid, 1);
        check("done_result", result, 1);
        @(negedge clk);
        #2;
        n_reset = 1'b0;
        #1;
        check("rst_done_busy", busy, 0);
        check("rst_done_valid", result_valid, 0);
        check("rst_done_result", result, 0);
        check("rst_done_timed_out", timed_out, 0);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        tick();
        mon_en = 1'b1;

        run_meas(1, 4, 0, 0, 1'b0, 0);    // works again after reset: 3
        tick();
        tick();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
